// File: rtl/mult_pkg.sv
// Shared constants and FSM state encoding for the shift-and-add multiplier.
package mult_pkg;
    localparam int WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/busy/done handshake and operand/result bus of the shift-and-add multiplier.
interface shift_add_multiplier_if;
    import mult_pkg::*;

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic                 done;

    modport master (output start, a, b, input product, busy, done);
    modport slave  (input start, a, b, output product, busy, done);
endinterface

// File: rtl/four_bit_adder.sv
// Plain 4-bit ripple-carry adder; the multiplier's only arithmetic element.
module four_bit_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    logic [4:0] w_c;

    assign w_c[0] = Cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign S[i]     = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end

    assign Cout = w_c[4];
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned multiplier: one add-and-shift per clock, 4 iterations,
// wrapped in a start/busy/done handshake.
module shift_add_multiplier
    import mult_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    shift_add_multiplier_if.slave  bus
);
    state_t               r_state;
    state_t               w_next_state;
    logic                 w_accept;

    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_q;
    logic [1:0]           r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_add_b;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;
    logic [WIDTH-1:0]     w_acc_sh;
    logic [WIDTH-1:0]     w_q_sh;

    assign w_add_b = r_q[0] ? r_mcand : '0;

    four_bit_adder u_adder (
        .A    (r_acc),
        .B    (w_add_b),
        .Cin  (1'b0),
        .S    (w_sum),
        .Cout (w_cout)
    );

    // {Cout,S,q} shifted right by one
    assign w_acc_sh = {w_cout, w_sum[WIDTH-1:1]};
    assign w_q_sh   = {w_sum[0], r_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next_state = ST_CALC;
                    w_accept     = 1'b1;
                end
            end
            ST_CALC: begin
                if (r_cnt == 2'd3) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_next_state = ST_CALC;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand <= bus.a;
            r_q     <= bus.b;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == ST_CALC) begin
            r_acc <= w_acc_sh;
            r_q   <= w_q_sh;
            r_cnt <= r_cnt + 2'd1;
            // Last iteration: publish the post-shift value so it is valid in DONE
            if (r_cnt == 2'd3) r_product <= {w_acc_sh, w_q_sh};
        end
    end

    assign bus.product = r_product;
    assign bus.busy    = (r_state == ST_CALC);
    assign bus.done    = (r_state == ST_DONE);
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: handshake timing, corner products,
// back-to-back operation, asynchronous reset and an exhaustive operand sweep.
module tb_shift_add_multiplier;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    shift_add_multiplier_if bus ();

    shift_add_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Presents an operand pair for exactly one rising edge; returns on the falling
    // edge right after the accepting edge.
    task automatic start_op(input logic [3:0] ia, input logic [3:0] ib);
        @(negedge clk);
        bus.a     = ia;
        bus.b     = ib;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.product, bus.busy, bus.done} !== 10'h000) begin
            n_errors++;
            $display("FAIL reset_state: got product=%h busy=%b done=%b, expected 00 0 0",
                     bus.product, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero();
        int busy_n;
        busy_n = 0;
        start_op(4'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            if (bus.busy === 1'b1 && bus.done === 1'b0) busy_n++;
            @(negedge clk);
        end
        n_checks++;
        if (busy_n != 4) begin
            n_errors++;
            $display("FAIL zero_busy_len: got %0d busy cycles, expected 4", busy_n);
        end
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.product !== 8'h00) begin
            n_errors++;
            $display("FAIL zero_done: got done=%b busy=%b product=%h, expected 1 0 00",
                     bus.done, bus.busy, bus.product);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_done_pulse: got done=%b busy=%b, expected 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_max();
        start_op(4'd15, 4'd15);
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || bus.product !== 8'hE1) begin
            n_errors++;
            $display("FAIL max_15x15: got done=%b product=%h, expected 1 e1", bus.done, bus.product);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.product !== 8'hE1) begin
            n_errors++;
            $display("FAIL max_hold: got done=%b product=%h, expected 0 e1", bus.done, bus.product);
        end
    endtask

    task automatic test_hold_start();
        @(negedge clk);
        bus.a     = 4'd13;
        bus.b     = 4'd11;
        bus.start = 1'b1;
        @(negedge clk);
        bus.a = 4'd2;
        bus.b = 4'd3;
        @(negedge clk);
        bus.a = 4'd7;
        bus.b = 4'd7;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_busy: got busy=%b done=%b, expected 1 0", bus.busy, bus.done);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || bus.product !== 8'h8F) begin
            n_errors++;
            $display("FAIL hold_13x11: got done=%b product=%h, expected 1 8f", bus.done, bus.product);
        end
        bus.start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_idle: got busy=%b done=%b, expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_back_to_back();
        start_op(4'd7, 4'd1);
        repeat (3) @(negedge clk);
        bus.a     = 4'd9;
        bus.b     = 4'd6;
        bus.start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || bus.product !== 8'h07) begin
            n_errors++;
            $display("FAIL b2b_first: got done=%b product=%h, expected 1 07", bus.done, bus.product);
        end
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.product !== 8'h07) begin
            n_errors++;
            $display("FAIL b2b_restart: got done=%b busy=%b product=%h, expected 0 1 07",
                     bus.done, bus.busy, bus.product);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || bus.product !== 8'h36) begin
            n_errors++;
            $display("FAIL b2b_second: got done=%b product=%h, expected 1 36", bus.done, bus.product);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        start_op(4'd12, 4'd12);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.product, bus.busy, bus.done} !== 10'h000) begin
            n_errors++;
            $display("FAIL async_reset: got product=%h busy=%b done=%b, expected 00 0 0",
                     bus.product, bus.busy, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_op(4'd3, 4'd5);
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || bus.product !== 8'h0F) begin
            n_errors++;
            $display("FAIL after_reset_3x5: got done=%b product=%h, expected 1 0f",
                     bus.done, bus.product);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        int busy_n;
        int bad_n;
        bad_n = 0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                busy_n = 0;
                start_op(4'(ia), 4'(ib));
                for (int k = 0; k < 4; k++) begin
                    if (bus.busy === 1'b1 && bus.done === 1'b0) busy_n++;
                    @(negedge clk);
                end
                n_checks++;
                if (busy_n != 4 || bus.done !== 1'b1 || bus.busy !== 1'b0 ||
                    bus.product !== 8'(ia * ib)) begin
                    n_errors++;
                    bad_n++;
                    if (bad_n <= 10)
                        $display("FAIL sweep_%0dx%0d: got product=%h done=%b busy=%b busy_cycles=%0d, expected %h 1 0 4",
                                 ia, ib, bus.product, bus.done, bus.busy, busy_n, 8'(ia * ib));
                end
                @(negedge clk);
                n_checks++;
                if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL sweep_pulse_%0dx%0d: got done=%b busy=%b, expected 0 0",
                             ia, ib, bus.done, bus.busy);
                end
            end
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        n_checks  = 0;
        n_errors  = 0;

        test_reset();
        test_zero();
        test_max();
        test_hold_start();
        test_back_to_back();
        test_async_reset();
        test_sweep();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
